// File: rtl/mux_rr_reg.sv
// N-channel valid/ready multiplexer with a registered output stage.
// Channel choice is either a static select or a round-robin scan that starts at ptr.
`timescale 1ns/1ps
module mux_rr_reg #(
   parameter int NCH   = 4,
   parameter int WIDTH = 8,
   parameter int SELW  = $clog2(NCH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 mode,
   input  logic [SELW-1:0]      sel,
   input  logic [NCH-1:0]       in_valid,
   input  logic [NCH*WIDTH-1:0] in_data,
   output logic [NCH-1:0]       in_ready,
   output logic                 out_valid,
   output logic [WIDTH-1:0]     out_data,
   output logic [SELW-1:0]      out_ch,
   input  logic                 out_ready
);

   // Handshake: a word moves on any side when valid and ready are both high
   // at a rising clk edge; valid never waits on ready, ready may depend on valid.

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [SELW-1:0]  out_ch_q, out_ch_d;
   logic [SELW-1:0]  ptr_q, ptr_d;

   logic             load_en;
   logic [NCH-1:0]   grant;
   logic [SELW-1:0]  grant_idx;
   logic             grant_any;
   logic             take;
   logic [WIDTH-1:0] grant_data;
   logic [SELW-1:0]  ptr_next;
   int               idx;

   assign load_en = !out_valid_q || out_ready;

   // Grant is one-hot or zero; the rotating scan picks the first requester at or after ptr.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      idx       = 0;
      if (!mode) begin
         if (int'(sel) < NCH) begin
            if (in_valid[sel]) begin
               grant[sel] = 1'b1;
               grant_idx  = sel;
               grant_any  = 1'b1;
            end
         end
      end else begin
         for (int off = 0; off < NCH; off++) begin
            idx = (int'(ptr_q) + off) % NCH;
            if (!grant_any && in_valid[idx]) begin
               grant[idx] = 1'b1;
               grant_idx  = SELW'(idx);
               grant_any  = 1'b1;
            end
         end
      end
   end

   assign in_ready   = (rst_n && load_en) ? grant : '0;
   assign take       = |(in_valid & in_ready);
   assign grant_data = in_data[int'(grant_idx)*WIDTH +: WIDTH];
   assign ptr_next   = (int'(grant_idx) == NCH-1) ? '0 : grant_idx + 1'b1;

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_ch_d    = out_ch_q;
      ptr_d       = ptr_q;
      if (take) begin
         out_valid_d = 1'b1;
         out_data_d  = grant_data;
         out_ch_d    = grant_idx;
         if (mode) begin
            ptr_d = ptr_next;
         end
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ch_q    <= '0;
         ptr_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_ch_q    <= out_ch_d;
         ptr_q       <= ptr_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_ch    = out_ch_q;

   // A stalled word must stay put, and at most one producer is accepted per cycle.
   a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(in_ready));
   a_stall_hold: assert property (@(posedge clk) disable iff (!rst_n)
      (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_ch)));

endmodule

// File: tb/tb_mux_rr_reg.sv
// Bench for mux_rr_reg: directed vector table, async reset sequence,
// then random traffic scored against a queue-based reference model.
`timescale 1ns/1ps
module tb_mux_rr_reg;

   localparam int NCH   = 4;
   localparam int WIDTH = 8;
   localparam int SELW  = 2;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 mode;
   logic [SELW-1:0]      sel;
   logic [NCH-1:0]       in_valid;
   logic [NCH*WIDTH-1:0] in_data;
   logic [NCH-1:0]       in_ready;
   logic                 out_valid;
   logic [WIDTH-1:0]     out_data;
   logic [SELW-1:0]      out_ch;
   logic                 out_ready;

   int total = 0;
   int bad   = 0;

   mux_rr_reg #(.NCH(NCH), .WIDTH(WIDTH)) dut (
      .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
      .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        mode;
      logic [1:0]  sel;
      logic [3:0]  vld;
      logic [31:0] data;
      logic        ordy;
      logic [3:0]  e_rdy;
      logic        e_ov;
      logic [1:0]  e_ch;
      logic [7:0]  e_od;
   } vec_t;

   vec_t tbl[$];

   logic [9:0] exp_q[$];
   int         m_ptr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic m, input logic [1:0] s, input logic [3:0] v,
                               input logic [31:0] d, input logic r, input logic [3:0] er,
                               input logic eov, input logic [1:0] ech, input logic [7:0] eod);
      vec_t t;
      t.mode = m; t.sel = s; t.vld = v; t.data = d; t.ordy = r;
      t.e_rdy = er; t.e_ov = eov; t.e_ch = ech; t.e_od = eod;
      return t;
   endfunction

   task automatic run_row(input vec_t v, input int n);
      mode = v.mode; sel = v.sel; in_valid = v.vld; in_data = v.data; out_ready = v.ordy;
      #1;
      chk($sformatf("row%0d in_ready", n), 32'(in_ready), 32'(v.e_rdy));
      @(posedge clk); #1;
      chk($sformatf("row%0d out_valid", n), 32'(out_valid), 32'(v.e_ov));
      chk($sformatf("row%0d out_ch", n), 32'(out_ch), 32'(v.e_ch));
      chk($sformatf("row%0d out_data", n), 32'(out_data), 32'(v.e_od));
   endtask

   // Reference arbitration: list the candidate channels in priority order, take the first valid one.
   function automatic int model_grant(input logic m, input logic [1:0] s, input logic [3:0] v, input int p);
      int cand[$];
      if (!m) begin
         if (int'(s) < NCH) cand.push_back(int'(s));
      end else begin
         for (int k = 0; k < NCH; k++) cand.push_back((p + k) % NCH);
      end
      foreach (cand[i]) if (v[cand[i]]) return cand[i];
      return -1;
   endfunction

   initial begin
      logic [31:0] dd, db;
      dd = 32'hA3A2A1A0;
      db = 32'hA3A25AA0;

      tbl.push_back(mk(0, 2, 4'hF, dd, 1, 4'b0100, 1, 2, 8'hA2));
      tbl.push_back(mk(0, 2, 4'hF, dd, 1, 4'b0100, 1, 2, 8'hA2));
      tbl.push_back(mk(0, 2, 4'hF, dd, 1, 4'b0100, 1, 2, 8'hA2));
      for (int r = 0; r < 2; r++) begin
         tbl.push_back(mk(1, 0, 4'hF, dd, 1, 4'b0001, 1, 0, 8'hA0));
         tbl.push_back(mk(1, 0, 4'hF, dd, 1, 4'b0010, 1, 1, 8'hA1));
         tbl.push_back(mk(1, 0, 4'hF, dd, 1, 4'b0100, 1, 2, 8'hA2));
         tbl.push_back(mk(1, 0, 4'hF, dd, 1, 4'b1000, 1, 3, 8'hA3));
      end
      tbl.push_back(mk(1, 0, 4'b0010, dd, 1, 4'b0010, 1, 1, 8'hA1));
      tbl.push_back(mk(1, 0, 4'b1010, dd, 1, 4'b1000, 1, 3, 8'hA3));
      tbl.push_back(mk(1, 0, 4'b1010, dd, 1, 4'b0010, 1, 1, 8'hA1));
      tbl.push_back(mk(1, 0, 4'b1010, dd, 1, 4'b1000, 1, 3, 8'hA3));
      tbl.push_back(mk(1, 0, 4'b0010, db, 1, 4'b0010, 1, 1, 8'h5A));
      for (int r = 0; r < 3; r++)
         tbl.push_back(mk(1, 0, 4'hF, db, 0, 4'b0000, 1, 1, 8'h5A));
      tbl.push_back(mk(1, 0, 4'hF, db, 1, 4'b0100, 1, 2, 8'hA2));
      tbl.push_back(mk(1, 0, 4'h0, db, 1, 4'b0000, 0, 2, 8'hA2));
      tbl.push_back(mk(1, 0, 4'h0, db, 0, 4'b0000, 0, 2, 8'hA2));
      tbl.push_back(mk(0, 1, 4'hF, db, 0, 4'b0010, 1, 1, 8'h5A));
      tbl.push_back(mk(1, 0, 4'hF, dd, 1, 4'b1000, 1, 3, 8'hA3));
      tbl.push_back(mk(1, 0, 4'hF, dd, 1, 4'b0001, 1, 0, 8'hA0));
      tbl.push_back(mk(1, 0, 4'hF, dd, 1, 4'b0010, 1, 1, 8'hA1));
      tbl.push_back(mk(1, 0, 4'hF, dd, 1, 4'b0100, 1, 2, 8'hA2));

      // Reset with every channel requesting.
      rst_n = 1'b0; mode = 1'b1; sel = '0; in_valid = 4'hF; in_data = dd; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst out_valid", 32'(out_valid), 32'd0);
      chk("rst out_data", 32'(out_data), 32'd0);
      chk("rst out_ch", 32'(out_ch), 32'd0);
      chk("rst in_ready", 32'(in_ready), 32'd0);
      in_valid = 4'h0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      foreach (tbl[i]) run_row(tbl[i], i + 1);

      // Async reset while a word is held and ptr sits at 3.
      #1;
      rst_n = 1'b0;
      #1;
      chk("async out_valid", 32'(out_valid), 32'd0);
      chk("async out_data", 32'(out_data), 32'd0);
      chk("async out_ch", 32'(out_ch), 32'd0);
      chk("async in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post-rst in_ready", 32'(in_ready), 32'b0001);
      @(posedge clk); #1;
      chk("post-rst out_valid", 32'(out_valid), 32'd1);
      chk("post-rst out_ch", 32'(out_ch), 32'd0);
      chk("post-rst out_data", 32'(out_data), 32'hA0);

      exp_q.delete();
      exp_q.push_back({2'd0, 8'hA0});
      m_ptr = 1;

      for (int c = 0; c < 400; c++) begin
         int       g;
         logic     ld;
         logic [3:0] er;
         logic [9:0] w;
         mode      = 1'($urandom_range(0, 1));
         sel       = 2'($urandom_range(0, NCH - 1));
         in_valid  = 4'($urandom);
         in_data   = $urandom;
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         g  = model_grant(mode, sel, in_valid, m_ptr);
         ld = (exp_q.size() == 0) || out_ready;
         er = (ld && g >= 0) ? 4'(1 << g) : 4'b0000;
         chk($sformatf("rnd%0d in_ready", c), 32'(in_ready), 32'(er));
         chk($sformatf("rnd%0d out_valid", c), 32'(out_valid), 32'(exp_q.size() != 0));
         if (exp_q.size() != 0) begin
            w = exp_q[0];
            chk($sformatf("rnd%0d out_word", c), 32'({out_ch, out_data}), 32'(w));
            if (out_ready) void'(exp_q.pop_front());
         end
         if (ld && g >= 0) begin
            w = {2'(g), in_data[g*WIDTH +: WIDTH]};
            exp_q.push_back(w);
            if (mode) m_ptr = (g + 1) % NCH;
         end
         @(posedge clk); #1;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
